// File: rtl/sram_mport_pipe.sv
// Multi-ported register-file SRAM with one-hot addresses, registered reads,
// optional write-to-read bypass and a sequential flush of entries CLR_LO..DEPTH-1.
module sram_mport_pipe #(
  parameter int DEPTH  = 64,
  parameter int WIDTH  = 8,
  parameter int NUM_RD = 16,
  parameter int NUM_WR = 8,
  parameter int CLR_LO = 0,
  parameter bit BYPASS = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_RD-1:0]       rd_en_i,
  input  logic [NUM_RD*DEPTH-1:0] rd_addr_i,
  input  logic [NUM_WR-1:0]       wr_en_i,
  input  logic [NUM_WR*DEPTH-1:0] wr_addr_i,
  input  logic [NUM_WR*WIDTH-1:0] wr_data_i,
  input  logic                    clear_i,
  output logic [NUM_RD*WIDTH-1:0] rd_data_o,
  output logic [NUM_RD-1:0]       rd_valid_o,
  output logic [NUM_RD*DEPTH-1:0] rd_addr_o,
  output logic [NUM_WR-1:0]       wr_en_o,
  output logic [NUM_WR*DEPTH-1:0] wr_addr_o,
  output logic                    wr_conflict_o,
  output logic                    busy_o
);

  // Pointer is wide enough to hold CLR_LO even when it lies beyond the array.
  localparam int               PTR_W  = $clog2(DEPTH + CLR_LO + 1);
  localparam bit               CLR_EN = (CLR_LO < DEPTH);
  localparam logic [PTR_W-1:0] PTR_LO = PTR_W'(CLR_LO);
  localparam logic [PTR_W-1:0] PTR_HI = PTR_W'(DEPTH - 1);

  typedef enum logic {
    ST_IDLE,
    ST_CLEAR
  } state_t;

  state_t                      state_q, state_d;
  logic [PTR_W-1:0]            ptr_q, ptr_d;
  logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
  logic [DEPTH-1:0][WIDTH-1:0] rd_src;
  logic [NUM_RD*WIDTH-1:0]     rd_mux;
  logic                        conflict_d;

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= PTR_LO;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (clear_i && CLR_EN) begin
          state_d = ST_CLEAR;
          ptr_d   = PTR_LO;
        end
      end
      ST_CLEAR: begin
        ptr_d = ptr_q + PTR_W'(1);
        if (ptr_q == PTR_HI) begin
          state_d = ST_IDLE;
          ptr_d   = PTR_LO;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Next-state array: ports in ascending order so the highest port wins, then the flush overrides.
  always_comb begin
    logic hit_seen;
    mem_d      = mem_q;
    conflict_d = 1'b0;
    hit_seen   = 1'b0;
    for (int e = 0; e < DEPTH; e++) begin
      hit_seen = 1'b0;
      for (int w = 0; w < NUM_WR; w++) begin
        if (wr_en_i[w] && wr_addr_i[w*DEPTH + e]) begin
          if (hit_seen) conflict_d = 1'b1;
          hit_seen = 1'b1;
          mem_d[e] = wr_data_i[w*WIDTH +: WIDTH];
        end
      end
      if ((state_q == ST_CLEAR) && (ptr_q == PTR_W'(e))) mem_d[e] = '0;
    end
  end

  for (genvar e = 0; e < DEPTH; e++) begin : g_ent
    logic [WIDTH-1:0] q;
    if (e < CLR_LO) begin : g_keep
      // NOTE: entries below CLR_LO are intentionally left out of the reset and keep contents across it.
      always_ff @(posedge clk) begin
        if (reset) q <= mem_d[e];
      end
    end else begin : g_clr
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) q <= '0;
        else        q <= mem_d[e];
      end
    end
    assign mem_q[e] = q;
  end

  assign rd_src = BYPASS ? mem_d : mem_q;

  // Read mux: all-zero address yields 0; the highest set address bit wins.
  always_comb begin
    rd_mux = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      for (int e = 0; e < DEPTH; e++) begin
        if (rd_addr_i[p*DEPTH + e]) rd_mux[p*WIDTH +: WIDTH] = rd_src[e];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_data_o     <= '0;
      rd_valid_o    <= '0;
      rd_addr_o     <= '0;
      wr_en_o       <= '0;
      wr_addr_o     <= '0;
      wr_conflict_o <= 1'b0;
      busy_o        <= 1'b0;
    end else begin
      for (int p = 0; p < NUM_RD; p++) begin
        if (rd_en_i[p]) rd_data_o[p*WIDTH +: WIDTH] <= rd_mux[p*WIDTH +: WIDTH];
      end
      rd_valid_o    <= rd_en_i;
      rd_addr_o     <= rd_addr_i;
      wr_en_o       <= wr_en_i;
      wr_addr_o     <= wr_addr_i;
      wr_conflict_o <= conflict_d;
      busy_o        <= (state_d == ST_CLEAR);
    end
  end

endmodule

// File: tb/tb_sram_mport_pipe.sv
// Scoreboard bench for sram_mport_pipe: two instances (bypass on/off) share stimulus
// and are compared each cycle against an array-level reference model.
module tb_sram_mport_pipe;
  localparam int D  = 128;
  localparam int W  = 32;
  localparam int NR = 4;
  localparam int NW = 2;
  localparam int LO = 32;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic [NR-1:0]   rd_en   = '0;
  logic [NR*D-1:0] rd_addr = '0;
  logic [NW-1:0]   wr_en   = '0;
  logic [NW*D-1:0] wr_addr = '0;
  logic [NW*W-1:0] wr_data = '0;
  logic            clear   = 1'b0;

  logic [NR*W-1:0] a_rd_data, b_rd_data;
  logic [NR-1:0]   a_rd_valid, b_rd_valid;
  logic [NR*D-1:0] a_rd_addr, b_rd_addr;
  logic [NW-1:0]   a_wr_en, b_wr_en;
  logic [NW*D-1:0] a_wr_addr, b_wr_addr;
  logic            a_conflict, b_conflict, a_busy, b_busy;

  always #5 clk = ~clk;

  sram_mport_pipe #(.DEPTH(D), .WIDTH(W), .NUM_RD(NR), .NUM_WR(NW), .CLR_LO(LO), .BYPASS(1'b1)) dut_a (
    .clk(clk), .reset(reset), .rd_en_i(rd_en), .rd_addr_i(rd_addr), .wr_en_i(wr_en),
    .wr_addr_i(wr_addr), .wr_data_i(wr_data), .clear_i(clear), .rd_data_o(a_rd_data),
    .rd_valid_o(a_rd_valid), .rd_addr_o(a_rd_addr), .wr_en_o(a_wr_en), .wr_addr_o(a_wr_addr),
    .wr_conflict_o(a_conflict), .busy_o(a_busy));

  sram_mport_pipe #(.DEPTH(D), .WIDTH(W), .NUM_RD(NR), .NUM_WR(NW), .CLR_LO(LO), .BYPASS(1'b0)) dut_b (
    .clk(clk), .reset(reset), .rd_en_i(rd_en), .rd_addr_i(rd_addr), .wr_en_i(wr_en),
    .wr_addr_i(wr_addr), .wr_data_i(wr_data), .clear_i(clear), .rd_data_o(b_rd_data),
    .rd_valid_o(b_rd_valid), .rd_addr_o(b_rd_addr), .wr_en_o(b_wr_en), .wr_addr_o(b_wr_addr),
    .wr_conflict_o(b_conflict), .busy_o(b_busy));

  typedef struct packed {
    logic [NR*W-1:0] rd_data_byp;
    logic [NR*W-1:0] rd_data_nob;
    logic [NR-1:0]   rd_valid;
    logic [NR*D-1:0] rd_addr;
    logic [NW-1:0]   wr_en;
    logic [NW*D-1:0] wr_addr;
    logic            conflict;
    logic            busy;
  } exp_t;

  exp_t exp_q[$];

  // Reference model state: whole array plus flush progress and held read values.
  logic [W-1:0] mdl_mem [D];
  bit           mdl_flush = 1'b0;
  int           mdl_ptr   = LO;
  logic [W-1:0] hold_byp [NR];
  logic [W-1:0] hold_nob [NR];

  int n_vec = 0;
  int n_bad = 0;
  int busy_cnt = 0;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [NR*D-1:0] rsel(input int p, input int e);
    logic [NR*D-1:0] v = '0;
    v[p*D + e] = 1'b1;
    return v;
  endfunction

  function automatic logic [NW*D-1:0] wsel(input int p, input int e);
    logic [NW*D-1:0] v = '0;
    v[p*D + e] = 1'b1;
    return v;
  endfunction

  function automatic logic [D-1:0] rand_addr();
    logic [D-1:0] a = '0;
    int r = $urandom_range(0, 9);
    if (r == 0) return a;
    a[$urandom_range(0, D-1)] = 1'b1;
    if (r >= 8) begin
      a[$urandom_range(0, D-1)] = 1'b1;
      a[$urandom_range(0, D-1)] = 1'b1;
    end
    return a;
  endfunction

  // Apply one cycle of stimulus, advance the model and queue the expected outputs.
  task automatic drive(input logic [NR-1:0] re, input logic [NR*D-1:0] ra, input logic [NW-1:0] we,
                       input logic [NW*D-1:0] wa, input logic [NW*W-1:0] wd, input logic clr);
    exp_t         x;
    logic [W-1:0] nxt [D];
    int           hits [D];
    int           top;
    @(negedge clk);
    rd_en = re; rd_addr = ra; wr_en = we; wr_addr = wa; wr_data = wd; clear = clr;
    x = '0;
    for (int e = 0; e < D; e++) begin
      nxt[e]  = mdl_mem[e];
      hits[e] = 0;
    end
    for (int w = 0; w < NW; w++) begin
      if (we[w]) begin
        for (int e = 0; e < D; e++) begin
          if (wa[w*D + e]) begin
            nxt[e] = wd[w*W +: W];
            hits[e]++;
          end
        end
      end
    end
    for (int e = 0; e < D; e++) if (hits[e] > 1) x.conflict = 1'b1;
    if (mdl_flush) begin
      nxt[mdl_ptr] = '0;
      if (mdl_ptr == D-1) mdl_flush = 1'b0;
      else mdl_ptr++;
    end else if (clr && LO < D) begin
      mdl_flush = 1'b1;
      mdl_ptr   = LO;
    end
    for (int p = 0; p < NR; p++) begin
      if (re[p]) begin
        top = -1;
        for (int e = D-1; e >= 0 && top < 0; e--) if (ra[p*D + e]) top = e;
        hold_byp[p] = (top < 0) ? '0 : nxt[top];
        hold_nob[p] = (top < 0) ? '0 : mdl_mem[top];
      end
      x.rd_data_byp[p*W +: W] = hold_byp[p];
      x.rd_data_nob[p*W +: W] = hold_nob[p];
    end
    for (int e = 0; e < D; e++) mdl_mem[e] = nxt[e];
    x.rd_valid = re;
    x.rd_addr  = ra;
    x.wr_en    = we;
    x.wr_addr  = wa;
    x.busy     = mdl_flush;
    exp_q.push_back(x);
  endtask

  task automatic idle();
    drive('0, '0, '0, '0, '0, 1'b0);
  endtask

  task automatic rand_cycle(input int clr_odds);
    logic [NR*D-1:0] ra;
    logic [NW*D-1:0] wa;
    logic [NW*W-1:0] wd;
    for (int p = 0; p < NR; p++) ra[p*D +: D] = rand_addr();
    for (int w = 0; w < NW; w++) begin
      wa[w*D +: D] = rand_addr();
      wd[w*W +: W] = $urandom();
    end
    if ($urandom_range(0, 5) == 0) wa[D +: D] = wa[0 +: D];
    drive(NR'($urandom()), ra, NW'($urandom()), wa, wd, ($urandom_range(0, clr_odds) == 0));
  endtask

  task automatic sweep_read();
    for (int i = 0; i < D/NR; i++)
      drive('1, rsel(0, 4*i) | rsel(1, 4*i+1) | rsel(2, 4*i+2) | rsel(3, 4*i+3), '0, '0, '0, 1'b0);
  endtask

  // Async reset between edges; outputs must drop before any clock edge.
  task automatic async_reset();
    @(posedge clk);
    #3;
    reset = 1'b0;
    rd_en = '0; rd_addr = '0; wr_en = '0; wr_addr = '0; wr_data = '0; clear = 1'b0;
    #1;
    check("rst a.rd_data", 512'(a_rd_data), '0);
    check("rst b.rd_data", 512'(b_rd_data), '0);
    check("rst a.rd_valid", 512'(a_rd_valid), '0);
    check("rst a.rd_addr", 512'(a_rd_addr), '0);
    check("rst a.wr_en", 512'(a_wr_en), '0);
    check("rst a.wr_addr", 512'(a_wr_addr), '0);
    check("rst a.conflict", 512'(a_conflict), '0);
    check("rst a.busy", 512'(a_busy), '0);
    check("rst b.busy", 512'(b_busy), '0);
    for (int e = LO; e < D; e++) mdl_mem[e] = '0;
    mdl_flush = 1'b0;
    mdl_ptr   = LO;
    for (int p = 0; p < NR; p++) begin
      hold_byp[p] = '0;
      hold_nob[p] = '0;
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  // Monitor: every cycle with reset released and an expectation queued, pop and compare.
  initial begin : monitor
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (a_busy === 1'b1) busy_cnt++;
      if (reset && exp_q.size() > 0) begin
        x = exp_q.pop_front();
        check("a.rd_data", 512'(a_rd_data), 512'(x.rd_data_byp));
        check("b.rd_data", 512'(b_rd_data), 512'(x.rd_data_nob));
        check("a.rd_valid", 512'(a_rd_valid), 512'(x.rd_valid));
        check("b.rd_valid", 512'(b_rd_valid), 512'(x.rd_valid));
        check("a.rd_addr", 512'(a_rd_addr), 512'(x.rd_addr));
        check("b.rd_addr", 512'(b_rd_addr), 512'(x.rd_addr));
        check("a.wr_en", 512'(a_wr_en), 512'(x.wr_en));
        check("b.wr_addr", 512'(b_wr_addr), 512'(x.wr_addr));
        check("a.wr_addr", 512'(a_wr_addr), 512'(x.wr_addr));
        check("a.conflict", 512'(a_conflict), 512'(x.conflict));
        check("b.conflict", 512'(b_conflict), 512'(x.conflict));
        check("a.busy", 512'(a_busy), 512'(x.busy));
        check("b.busy", 512'(b_busy), 512'(x.busy));
      end
    end
  end

  initial begin : stimulus
    for (int p = 0; p < NR; p++) begin
      hold_byp[p] = '0;
      hold_nob[p] = '0;
    end
    for (int e = 0; e < D; e++) mdl_mem[e] = '0;
    #1 reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Reads straight after reset (entries in the cleared range) return 0.
    drive(4'b0111, rsel(0, LO) | rsel(1, LO+5) | rsel(2, D-1), '0, '0, '0, 1'b0);

    // Preload the whole array so every entry has a known value.
    for (int i = 0; i < D/2; i++)
      drive('0, '0, 2'b11, wsel(0, 2*i) | wsel(1, 2*i+1), {NW{32'hFFFF_FFFF}}, 1'b0);

    // Same-cycle write and read of entry 10, then a repeat read.
    drive(4'b1000, rsel(3, 10), 2'b10, wsel(1, 10), {32'h0000_00A5, 32'h0}, 1'b0);
    drive(4'b1000, rsel(3, 10), '0, '0, '0, 1'b0);

    // Both write ports hit entry 4; the higher port's data must stick.
    drive('0, '0, 2'b11, wsel(0, 4) | wsel(1, 4), {32'h0000_0077, 32'h0000_0011}, 1'b0);
    drive(4'b0001, rsel(0, 4), '0, '0, '0, 1'b0);
    idle();

    // Flush of the upper range with writes racing the pointer and a re-pulse while busy.
    busy_cnt = 0;
    drive('0, '0, '0, '0, '0, 1'b1);
    for (int k = 1; k <= D-LO; k++) begin
      if (k == 9)
        drive(4'b0001, rsel(0, LO+k-1), 2'b01, wsel(0, 40), {32'h0, 32'h0000_DEAD}, 1'b0);
      else if (k == 10)
        drive(4'b0001, rsel(0, 40), 2'b01, wsel(0, 40), {32'h0, 32'h0000_1234}, 1'b0);
      else
        drive(4'b0011, rsel(0, LO+k-1) | rsel(1, 3), '0, '0, '0, (k == 20));
    end
    idle();
    idle();
    sweep_read();
    check("flush busy cycles", 512'(busy_cnt), 512'(D-LO));

    // Random traffic with occasional flush requests.
    for (int i = 0; i < 1500; i++) rand_cycle(60);

    // Reset in the middle of a flush, once the pointer has reached 45.
    for (int i = 0; i < 200 && mdl_flush; i++) idle();
    drive('0, '0, '0, '0, '0, 1'b1);
    for (int k = 0; k < 45 - LO; k++) rand_cycle(1000);
    async_reset();
    sweep_read();
    for (int i = 0; i < 300; i++) rand_cycle(80);
    idle();

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    @(posedge clk);
    #2;
    check("scoreboard drained", 512'(exp_q.size()), '0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
